// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array output drain.
// Optional feature macro used by sa_out_drain: SA_DRAIN_DROP_CNT_EN.
package sa_pkg;

    localparam int SA_D_W    = 16;
    localparam int SA_R_DEF  = 16;
    localparam int SA_C_DEF  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } sa_state_e;

    function automatic int elem_off(
        input int r,
        input int c,
        input int sa_c,
        input int d_w
    );
        return (r * sa_c + c) * d_w;
    endfunction

endpackage

// File: rtl/sa_row_mux.sv
// Combinational row selector: picks one SA_C-element row out of the
// captured result matrix by row index.
module sa_row_mux
    import sa_pkg::*;
#(
    parameter int D_W  = SA_D_W,
    parameter int SA_R = SA_R_DEF,
    parameter int SA_C = SA_C_DEF,
    parameter int RI_W = (SA_R > 1) ? $clog2(SA_R) : 1
) (
    input  logic [SA_R*SA_C*D_W-1:0] I_BUF,
    input  logic [RI_W-1:0]          I_IDX,
    output logic [SA_C*D_W-1:0]      O_ROW
);

    localparam int BUF_W = SA_R * SA_C * D_W;
    localparam int OFF_W = (BUF_W > 1) ? $clog2(BUF_W) : 1;

    logic [OFF_W-1:0] off;

    always_comb begin
        O_ROW = '0;
        off   = '0;
        for (int c = 0; c < SA_C; c++) begin
            off = OFF_W'(elem_off(int'(I_IDX), c, SA_C, D_W));
            O_ROW[c*D_W +: D_W] = I_BUF[off +: D_W];
        end
    end

endmodule

// File: rtl/sa_out_drain.sv
// Captures a full SA result tile and streams it out one row per beat.
// Define SA_DRAIN_DROP_CNT_EN to build the saturating drop counter.
module sa_out_drain
    import sa_pkg::*;
#(
    parameter int D_W  = SA_D_W,
    parameter int SA_R = SA_R_DEF,
    parameter int SA_C = SA_C_DEF,
    parameter int RI_W = (SA_R > 1) ? $clog2(SA_R) : 1
) (
    input  logic                     I_CLK,
    input  logic                     I_ASYN_RST,
    input  logic                     I_OUT_VLD,
    input  logic [SA_R*SA_C*D_W-1:0] I_OUT,
    input  logic                     I_RDY,
    output logic                     O_VLD,
    output logic [SA_C*D_W-1:0]      O_ROW,
    output logic [RI_W-1:0]          O_ROW_IDX,
    output logic                     O_LAST,
    output logic                     O_BUSY,
    output logic                     O_DROP,
    output logic [7:0]               O_DROP_CNT
);

    localparam int              BUF_W    = SA_R * SA_C * D_W;
    localparam logic [RI_W-1:0] LAST_IDX = RI_W'(SA_R - 1);

    sa_state_e        state;
    logic [BUF_W-1:0] tile_buf;
    logic [RI_W-1:0]  row_idx;
    logic             drop_q;

    logic busy;
    logic xfer;
    logic last_row;
    logic cap;
    logic refuse;

    assign busy     = (state == ST_DRAIN);
    assign xfer     = busy && I_RDY;
    assign last_row = (row_idx == LAST_IDX);
    // A new tile is only taken when the buffer is free by the next edge.
    assign cap      = I_OUT_VLD && (!busy || (xfer && last_row));
    assign refuse   = I_OUT_VLD && !cap;

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            state    <= ST_IDLE;
            row_idx  <= '0;
            tile_buf <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= refuse;
            if (cap) begin
                tile_buf <= I_OUT;
                row_idx  <= '0;
                state    <= ST_DRAIN;
            end else if (xfer) begin
                if (last_row) begin
                    state   <= ST_IDLE;
                    row_idx <= '0;
                end else begin
                    row_idx <= row_idx + RI_W'(1);
                end
            end
        end
    end

`ifdef SA_DRAIN_DROP_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            drop_cnt <= 8'd0;
        end else if (refuse && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign O_DROP_CNT = drop_cnt;
`else
    assign O_DROP_CNT = 8'd0;
`endif

    sa_row_mux #(
        .D_W  (D_W),
        .SA_R (SA_R),
        .SA_C (SA_C),
        .RI_W (RI_W)
    ) u_row_mux (
        .I_BUF (tile_buf),
        .I_IDX (row_idx),
        .O_ROW (O_ROW)
    );

    assign O_VLD     = busy;
    assign O_BUSY    = busy;
    assign O_ROW_IDX = row_idx;
    assign O_LAST    = busy && last_row;
    assign O_DROP    = drop_q;

endmodule

// File: tb/tb_sa_out_drain.sv
// Testbench for sa_out_drain, 4x4 tile of 16-bit elements.
// Directed vector table, reset corner cases, then queue-model random run.
module tb_sa_out_drain;

    localparam int D_W  = 16;
    localparam int SA_R = 4;
    localparam int SA_C = 4;

`ifdef SA_DRAIN_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         I_CLK = 1'b0;
    logic         I_ASYN_RST;
    logic         I_OUT_VLD;
    logic [255:0] I_OUT;
    logic         I_RDY;
    logic         O_VLD;
    logic [63:0]  O_ROW;
    logic [1:0]   O_ROW_IDX;
    logic         O_LAST;
    logic         O_BUSY;
    logic         O_DROP;
    logic [7:0]   O_DROP_CNT;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 I_CLK = ~I_CLK;

    sa_out_drain #(
        .D_W  (D_W),
        .SA_R (SA_R),
        .SA_C (SA_C)
    ) dut (
        .I_CLK      (I_CLK),
        .I_ASYN_RST (I_ASYN_RST),
        .I_OUT_VLD  (I_OUT_VLD),
        .I_OUT      (I_OUT),
        .I_RDY      (I_RDY),
        .O_VLD      (O_VLD),
        .O_ROW      (O_ROW),
        .O_ROW_IDX  (O_ROW_IDX),
        .O_LAST     (O_LAST),
        .O_BUSY     (O_BUSY),
        .O_DROP     (O_DROP),
        .O_DROP_CNT (O_DROP_CNT)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Tile patterns: 0 ramp 0x0100*r+c, 1 all 0x7FFF, 2 all 0xE000 (-1.0).
    function automatic logic [255:0] tile_of(input int sel);
        logic [255:0] t;
        t = '0;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                case (sel)
                    0: t[(r*SA_C+c)*D_W +: D_W] = 16'(16'h0100 * r + c);
                    1: t[(r*SA_C+c)*D_W +: D_W] = 16'h7FFF;
                    default: t[(r*SA_C+c)*D_W +: D_W] = 16'hE000;
                endcase
        return t;
    endfunction

    function automatic logic [63:0] row_of(input logic [255:0] t, input int r);
        return t[r*64 +: 64];
    endfunction

    typedef struct {
        logic vld;
        logic rdy;
        int   tile;
        logic e_vld;
        int   e_idx;
        logic e_last;
        logic e_drop;
        int   e_cnt;
        int   e_tile;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic r, input int t,
                       input logic ev, input int ei, input logic el,
                       input logic ed, input int ec, input int et);
        vec_t e;
        e.vld = v; e.rdy = r; e.tile = t;
        e.e_vld = ev; e.e_idx = ei; e.e_last = el;
        e.e_drop = ed; e.e_cnt = ec; e.e_tile = et;
        tbl.push_back(e);
    endtask

    // Reference model: queue of rows still owed downstream.
    logic [63:0] mq[$];
    logic        m_drop;
    int          m_cnt;

    task automatic model_clear();
        mq.delete();
        m_drop = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_update(input logic v, input logic r,
                                input logic [255:0] t);
        bit has, xfer, cap;
        has  = (mq.size() != 0);
        xfer = has && r;
        cap  = v && (!has || (mq.size() == 1 && r));
        m_drop = v && !cap;
        if (m_drop && CNT_EN && m_cnt < 255) m_cnt++;
        if (xfer) void'(mq.pop_front());
        if (cap)
            for (int i = 0; i < SA_R; i++) mq.push_back(row_of(t, i));
    endtask

    task automatic check_model();
        logic ev;
        ev = (mq.size() != 0);
        chk("m_vld", 64'(O_VLD), 64'(ev));
        chk("m_busy", 64'(O_BUSY), 64'(ev));
        chk("m_last", 64'(O_LAST), 64'(ev && mq.size() == 1));
        chk("m_drop", 64'(O_DROP), 64'(m_drop));
        chk("m_cnt", 64'(O_DROP_CNT), 64'(m_cnt));
        if (ev) begin
            chk("m_idx", 64'(O_ROW_IDX), 64'(SA_R - mq.size()));
            chk("m_row", O_ROW, mq[0]);
        end
    endtask

    task automatic mstep(input logic v, input logic r, input logic [255:0] t);
        check_model();
        I_OUT_VLD = v;
        I_RDY     = r;
        I_OUT     = t;
        model_update(v, r, t);
        @(negedge I_CLK);
    endtask

    function automatic logic [255:0] rand_tile();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    initial begin
        I_ASYN_RST = 1'b1;
        I_OUT_VLD  = 1'b0;
        I_OUT      = '0;
        I_RDY      = 1'b0;

        //  vld rdy tile | vld idx last drop cnt tile
        add(1, 1, 0,  1, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 1, 0, 0, 0, 0);
        add(0, 1, 0,  1, 2, 0, 0, 0, 0);
        add(0, 1, 0,  1, 3, 1, 0, 0, 0);
        add(0, 1, 0,  0, 0, 0, 0, 0, 0);
        add(1, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 1, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 1, 0,  1, 2, 0, 0, 0, 0);
        add(0, 0, 0,  1, 2, 0, 0, 0, 0);
        add(0, 0, 0,  1, 2, 0, 0, 0, 0);
        add(0, 1, 0,  1, 3, 1, 0, 0, 0);
        add(0, 0, 0,  1, 3, 1, 0, 0, 0);
        add(1, 1, 1,  1, 0, 0, 0, 0, 1);
        add(0, 1, 0,  1, 1, 0, 0, 0, 1);
        add(1, 0, 2,  1, 1, 0, 1, 1, 1);
        add(0, 1, 0,  1, 2, 0, 0, 1, 1);
        add(0, 1, 0,  1, 3, 1, 0, 1, 1);
        add(0, 1, 0,  0, 0, 0, 0, 1, 1);
        add(1, 1, 2,  1, 0, 0, 0, 1, 2);
        add(0, 1, 0,  1, 1, 0, 0, 1, 2);
        add(0, 1, 0,  1, 2, 0, 0, 1, 2);
        add(0, 1, 0,  1, 3, 1, 0, 1, 2);
        add(0, 1, 0,  0, 0, 0, 0, 1, 2);
        add(1, 0, 0,  1, 0, 0, 0, 1, 0);
        add(1, 0, 0,  1, 0, 0, 1, 2, 0);
        add(0, 1, 0,  1, 1, 0, 0, 2, 0);
        add(0, 1, 0,  1, 2, 0, 0, 2, 0);

        @(negedge I_CLK);
        @(negedge I_CLK);
        chk("rst_vld", 64'(O_VLD), 64'd0);
        chk("rst_row", O_ROW, 64'd0);
        chk("rst_idx", 64'(O_ROW_IDX), 64'd0);
        chk("rst_last", 64'(O_LAST), 64'd0);
        chk("rst_busy", 64'(O_BUSY), 64'd0);
        chk("rst_drop", 64'(O_DROP), 64'd0);
        chk("rst_cnt", 64'(O_DROP_CNT), 64'd0);
        I_ASYN_RST = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            I_OUT_VLD = tbl[i].vld;
            I_RDY     = tbl[i].rdy;
            I_OUT     = tile_of(tbl[i].tile);
            @(negedge I_CLK);
            chk($sformatf("v%0d_vld", i), 64'(O_VLD), 64'(tbl[i].e_vld));
            chk($sformatf("v%0d_busy", i), 64'(O_BUSY), 64'(tbl[i].e_vld));
            chk($sformatf("v%0d_last", i), 64'(O_LAST), 64'(tbl[i].e_last));
            chk($sformatf("v%0d_drop", i), 64'(O_DROP), 64'(tbl[i].e_drop));
            chk($sformatf("v%0d_cnt", i), 64'(O_DROP_CNT),
                CNT_EN ? 64'(tbl[i].e_cnt) : 64'd0);
            if (tbl[i].e_vld) begin
                chk($sformatf("v%0d_idx", i), 64'(O_ROW_IDX), 64'(tbl[i].e_idx));
                chk($sformatf("v%0d_row", i), O_ROW,
                    row_of(tile_of(tbl[i].e_tile), tbl[i].e_idx));
            end
            if (i == 2) chk("row2_const", O_ROW, 64'h0203_0202_0201_0200);
        end

        // Asynchronous reset in the middle of a drain (row 2 showing).
        I_OUT_VLD = 1'b0;
        #2 I_ASYN_RST = 1'b1;
        #1;
        chk("arst_vld", 64'(O_VLD), 64'd0);
        chk("arst_busy", 64'(O_BUSY), 64'd0);
        chk("arst_idx", 64'(O_ROW_IDX), 64'd0);
        chk("arst_last", 64'(O_LAST), 64'd0);
        @(negedge I_CLK);
        I_ASYN_RST = 1'b0;
        I_RDY      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge I_CLK);
            chk("post_rst_idle", 64'(O_VLD), 64'd0);
        end
        I_OUT_VLD = 1'b1;
        I_OUT     = tile_of(0);
        @(negedge I_CLK);
        I_OUT_VLD = 1'b0;
        chk("restart_vld", 64'(O_VLD), 64'd1);
        chk("restart_idx", 64'(O_ROW_IDX), 64'd0);
        chk("restart_row", O_ROW, row_of(tile_of(0), 0));

        I_ASYN_RST = 1'b1;
        @(negedge I_CLK);
        I_ASYN_RST = 1'b0;
        model_clear();

        for (int i = 0; i < 1500; i++)
            mstep(($urandom % 4) == 0, ($urandom % 4) != 0, rand_tile());

        for (int i = 0; i < 301; i++)
            mstep(1'b1, 1'b0, rand_tile());
        chk("drop_sat", 64'(O_DROP_CNT), CNT_EN ? 64'd255 : 64'd0);
        chk("drop_hold", 64'(O_DROP), 64'd1);

        for (int i = 0; i < 8; i++)
            mstep(1'b0, 1'b1, '0);
        check_model();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sa_out_drain.md
Name: sa_out_drain

Overview:
- Reader side of the systolic-array output bus: captures the full SA_R x SA_C result matrix when the array flags it valid.
- Streams the matrix out one row (SA_C elements) per accepted transfer on a valid/ready interface.
- Sits between the SA wrapper output and the downstream softmax/accumulate stages in the MHA datapath.
- Frees the array to start the next tile as soon as the capture is taken.

Parameters:
- D_W, 16, element width (Q2.13 signed: 1 sign, 2 int, 13 frac bits).
- SA_R, 16, rows of the result matrix, i.e. number of output beats per tile.
- SA_C, 16, columns, i.e. elements per output beat.
- RI_W, $clog2(SA_R) (minimum 1), width of the row index.

Ports:
- I_CLK  input  1  clock.
- I_ASYN_RST  input  1  asynchronous reset, active-high.
- I_OUT_VLD  input  1  single-cycle pulse: I_OUT holds a complete result tile.
- I_OUT  input  SA_R*SA_C*D_W  result matrix; element (r,c) at bits [(r*SA_C+c)*D_W +: D_W].
- I_RDY  input  1  downstream ready.
- O_VLD  output  1  O_ROW is valid.
- O_ROW  output  SA_C*D_W  current row; element c at [c*D_W +: D_W].
- O_ROW_IDX  output  RI_W  index of the row on O_ROW.
- O_LAST  output  1  O_VLD and O_ROW_IDX==SA_R-1.
- O_BUSY  output  1  high in DRAIN state.
- O_DROP  output  1  one-cycle pulse when a capture is refused.
- O_DROP_CNT  output  8  dropped-capture count (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state IDLE, buffer cleared to 0, row index 0.
- Reset mid-drain aborts the drain immediately. No partial tile is resumed.
- States:
  - IDLE: O_VLD=0. I_OUT_VLD=1 latches I_OUT into the buffer, row index <= 0, next state DRAIN.
  - DRAIN: O_VLD=1. A transfer occurs on O_VLD&&I_RDY.
    - Transfer with row index < SA_R-1: row index increments.
    - Transfer with row index == SA_R-1: go to IDLE.
- Latency: I_OUT_VLD in cycle t gives O_VLD=1 with row 0 in cycle t+1. Minimum drain time is SA_R cycles with I_RDY held high.
- O_VLD, O_ROW, O_ROW_IDX stay stable while O_VLD && !I_RDY. O_VLD never drops without a transfer.
- O_ROW is a mux of the buffer by registered row index. No arithmetic is performed and the data passes through bit-exact.
- Boundary cases:
  - I_OUT_VLD coincident with the last transfer: new tile captured, state stays DRAIN, row index <= 0. Back-to-back with no bubble.
  - I_OUT_VLD in DRAIN at any other time: tile ignored, buffer untouched, O_DROP=1 for one cycle.
  - I_OUT_VLD held high for several cycles in IDLE: only the first cycle captures. Later cycles fall under the drop rule.
  - SA_R=1: every transfer is last. O_LAST=O_VLD.
- O_BUSY = (state==DRAIN).

Optional Feature:
- Macro SA_DRAIN_DROP_CNT_EN.
- Defined: O_DROP_CNT increments on each O_DROP pulse, saturates at 255, and clears only on reset.
- Undefined: O_DROP_CNT is tied to 0 and no counter register exists. O_DROP still pulses.

Decomposition:
- Shared package sa_pkg holds:
  - default D_W/SA_R/SA_C constants;
  - a state enum type (IDLE, DRAIN);
  - a helper function for the element bit offset (r*SA_C+c)*D_W.
- One natural sub-module: sa_row_mux. It is combinational, taking the buffer and row index and returning one row. It is reused by later column-drain variants.
- The FSM, counter and buffer stay in sa_out_drain.

Test Plan (SA_R=SA_C=4, D_W=16 build):
1. Load elements 16'h0100*r+c, pulse I_OUT_VLD, hold I_RDY=1 -> O_VLD one cycle later. Rows 0..3 appear on 4 consecutive cycles with O_ROW_IDX 0..3. O_LAST is set only on row 3. Row 2 reads {16'h0203,16'h0202,16'h0201,16'h0200}.
2. Toggle I_RDY 1,0,0,1,... -> rows are never skipped or duplicated, and O_ROW holds during stalls. The drain completes after exactly 4 accepted beats.
3. Pulse I_OUT_VLD on the row-3 transfer cycle with a new tile (all 16'h7FFF) -> next cycle shows row 0 = 4x16'h7FFF. No idle cycle and no O_DROP.
4. Pulse I_OUT_VLD during row 1 -> O_DROP pulses once and the remaining rows still carry the old tile. With SA_DRAIN_DROP_CNT_EN, O_DROP_CNT=1. After 300 drops it reads 255.
5. Assert I_ASYN_RST mid-drain at row 2 -> O_VLD, O_BUSY, O_ROW_IDX go to 0 asynchronously. After release there is no output until the next I_OUT_VLD, which restarts at row 0.
6. Negative data 16'hE000 (-1.0) in all elements -> passes through bit-exact on all 4 rows.
